// File: rtl/mux4x1_tristate_decoder.sv
// rtl/mux4x1_tristate_decoder.sv - 4:1 select as 2-to-4 decoder into a resolved shared bus, with registered copies
module mux4x1_tristate_decoder #(
    parameter int WIDTH    = 1,
    parameter bit BUS_PULL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] A,
    input  logic [1:0]         S,
    input  logic               EN,
    output logic [WIDTH-1:0]   OUT,
    output logic [WIDTH-1:0]   OUT_R,
    output logic [3:0]         DEC_R,
    output logic               BUS_Z
);

    logic [3:0]       dec;
    logic [WIDTH-1:0] bus_drv;

    // Unknown S or EN matches no case item, so the decoder stays all-zero.
    always_comb begin
        dec = 4'b0000;
        if (EN) begin
            case (S)
                2'd0:    dec = 4'b0001;
                2'd1:    dec = 4'b0010;
                2'd2:    dec = 4'b0100;
                2'd3:    dec = 4'b1000;
                default: dec = 4'b0000;
            endcase
        end
    end

    // Bus resolution: dec is one-hot or zero, so at most one lane ever drives.
    always_comb begin
        bus_drv = '0;
        for (int i = 0; i < 4; i++) begin
            if (dec[i]) begin
                bus_drv = bus_drv | A[i*WIDTH +: WIDTH];
            end
        end
    end

    assign BUS_Z = ~|dec;
    assign OUT   = BUS_Z ? {WIDTH{BUS_PULL}} : bus_drv;

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_R <= '0;
            DEC_R <= 4'b0000;
        end else begin
            OUT_R <= OUT;
            DEC_R <= dec;
        end
    end

endmodule

// File: tb/tb_mux4x1_tristate_decoder.sv
// tb/tb_mux4x1_tristate_decoder.sv - directed bench for mux4x1_tristate_decoder
module tb_mux4x1_tristate_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a1;
    logic [31:0] a8;
    logic [1:0]  s;
    logic        en;

    logic       out0, out_r0, bus_z0;
    logic [3:0] dec_r0;
    logic       out1, out_r1, bus_z1;
    logic [3:0] dec_r1;
    logic [7:0] out8, out_r8;
    logic [3:0] dec_r8;
    logic       bus_z8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux4x1_tristate_decoder #(.WIDTH(1), .BUS_PULL(1'b0)) u_dut (
        .clk(clk), .rst(rst), .A(a1), .S(s), .EN(en),
        .OUT(out0), .OUT_R(out_r0), .DEC_R(dec_r0), .BUS_Z(bus_z0)
    );

    mux4x1_tristate_decoder #(.WIDTH(1), .BUS_PULL(1'b1)) u_dut_pu (
        .clk(clk), .rst(rst), .A(a1), .S(s), .EN(en),
        .OUT(out1), .OUT_R(out_r1), .DEC_R(dec_r1), .BUS_Z(bus_z1)
    );

    mux4x1_tristate_decoder #(.WIDTH(8), .BUS_PULL(1'b0)) u_dut_w8 (
        .clk(clk), .rst(rst), .A(a8), .S(s), .EN(en),
        .OUT(out8), .OUT_R(out_r8), .DEC_R(dec_r8), .BUS_Z(bus_z8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic        exp_t1 [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        exp_t2 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0]  exp_t6 [4] = '{8'h5A, 8'hFF, 8'h00, 8'hD4};
    logic [3:0]  exp_dec[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst = 1'b1;
        a1  = 4'b0000;
        a8  = 32'h0;
        s   = 2'd0;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_r", {31'b0, out_r0}, 32'd0);
        check("reset_dec_r", {28'b0, dec_r0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        en = 1'b1;
        a1 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #10;
            check("t1_out", {31'b0, out0}, {31'b0, exp_t1[i]});
            check("t1_bus_z", {31'b0, bus_z0}, 32'd0);
        end

        a1 = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #10;
            check("t2_out", {31'b0, out0}, {31'b0, exp_t2[i]});
        end
        s  = 2'd1;
        a1 = 4'b1101;
        #1 check("t2_track_a0", {31'b0, out0}, 32'd0);
        a1 = 4'b0010;
        #1 check("t2_track_a1", {31'b0, out0}, 32'd1);
        a1 = 4'b0100;
        s  = 2'd2;
        #1 check("t2_same_step", {31'b0, out0}, 32'd1);

        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s  = 2'(i);
            a1 = 4'b1111 ^ 4'(i);
            #10;
            check("t3_out_pd", {31'b0, out0}, 32'd0);
            check("t3_bus_z", {31'b0, bus_z0}, 32'd1);
            check("t3_out_pu", {31'b0, out1}, 32'd1);
        end
        en = 1'b1;
        a1 = 4'b1011;
        s  = 2'd2;
        #1 check("t3_pu_enabled", {31'b0, out1}, 32'd0);

        @(negedge clk);
        en = 1'b1;
        a1 = 4'b1011;
        s  = 2'd3;
        @(posedge clk);
        #1;
        check("t4_out_r_s3", {31'b0, out_r0}, 32'd1);
        check("t4_dec_r_s3", {28'b0, dec_r0}, 32'b1000);
        @(negedge clk);
        s = 2'd2;
        @(posedge clk);
        #1;
        check("t4_out_r_s2", {31'b0, out_r0}, 32'd0);
        check("t4_dec_r_s2", {28'b0, dec_r0}, 32'b0100);

        @(negedge clk);
        s   = 2'd3;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("t5_rst_out_r", {31'b0, out_r0}, 32'd0);
            check("t5_rst_dec_r", {28'b0, dec_r0}, 32'd0);
            check("t5_rst_out", {31'b0, out0}, 32'd1);
            check("t5_rst_bus_z", {31'b0, bus_z0}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_rel_out_r", {31'b0, out_r0}, 32'd1);
        check("t5_rel_dec_r", {28'b0, dec_r0}, 32'b1000);

        @(negedge clk);
        a8 = {8'hD4, 8'h00, 8'hFF, 8'h5A};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = 2'(i);
            #1;
            check("t6_out8", {24'b0, out8}, {24'b0, exp_t6[i]});
        end
        @(posedge clk);
        #1;
        check("t6_out_r8", {24'b0, out_r8}, 32'hD4);

        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                en = e[0];
                s  = 2'(i);
                @(posedge clk);
                #1;
                check("t6_onehot", {31'b0, ($countones(dec_r8) <= 1)}, 32'd1);
                check("t6_dec_r", {28'b0, dec_r8}, {28'b0, (e != 0) ? exp_dec[i] : 4'b0000});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
